// File: rtl/buck_phase_sequencer.sv
// Soft-start and phase add/shed controller for the multiphase buck PWM chain.
// Duty and phase changes land only on PWM period boundaries; fault and disable override at once.
module buck_phase_sequencer #(
  parameter int unsigned DW        = 10,
  parameter int unsigned NPHASES   = 4,
  parameter int unsigned RAMP_STEP = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_period_tick,
  input  logic               i_en_pwm,
  input  logic               i_mode_manual,
  input  logic [DW-1:0]      i_duty_manual,
  input  logic [DW-1:0]      i_duty_loop,
  input  logic [DW-1:0]      i_duty_max,
  input  logic [2:0]         i_phase_req,
  input  logic               i_fault,
  output logic [DW-1:0]      o_duty_out,
  output logic [NPHASES-1:0] o_phase_en,
  output logic [1:0]         o_state,
  output logic               o_ready,
  output logic               o_fault_latched
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRamp  = 2'd1,
    StRun   = 2'd2,
    StFault = 2'd3
  } state_e;

  localparam logic [DW-1:0] LP_STEP = DW'(RAMP_STEP);
  localparam logic [2:0]    LP_NMAX = 3'(NPHASES);

  state_e             r_state;
  state_e             w_state_d;
  logic [DW-1:0]      r_duty;
  logic [DW-1:0]      w_duty_d;
  logic [NPHASES-1:0] r_phase;
  logic [NPHASES-1:0] w_phase_d;
  logic               r_ready;
  logic               r_fault_latched;

  logic [DW-1:0]      w_sel;
  logic [DW-1:0]      w_target;
  logic [DW:0]        w_sum;
  logic [2:0]         w_nreq;
  logic [NPHASES:0]   w_req_mask;

  assign w_sel    = i_mode_manual ? i_duty_manual : i_duty_loop;
  assign w_target = (w_sel > i_duty_max) ? i_duty_max : w_sel;
  // One extra bit so the ramp sum can never wrap past the target.
  assign w_sum    = {1'b0, r_duty} + {1'b0, LP_STEP};

  always_comb begin
    w_nreq = i_phase_req;
    if (i_phase_req == 3'd0) begin
      w_nreq = 3'd1;
    end else if (i_phase_req > LP_NMAX) begin
      w_nreq = LP_NMAX;
    end
  end

  // Thermometer codes order numerically, so a plain compare gives the step direction.
  assign w_req_mask = ({{NPHASES{1'b0}}, 1'b1} << w_nreq) - {{NPHASES{1'b0}}, 1'b1};

  always_comb begin
    w_state_d = r_state;
    w_duty_d  = r_duty;
    w_phase_d = r_phase;
    case (r_state)
      StIdle: begin
        w_duty_d  = '0;
        w_phase_d = '0;
        if (i_period_tick && i_en_pwm && !i_fault) begin
          w_state_d = StRamp;
          w_phase_d = NPHASES'(1);
          w_duty_d  = (w_target < LP_STEP) ? w_target : LP_STEP;
        end
      end
      StRamp, StRun: begin
        if (i_fault) begin
          w_state_d = StFault;
          w_duty_d  = '0;
          w_phase_d = '0;
        end else if (!i_en_pwm) begin
          w_state_d = StIdle;
          w_duty_d  = '0;
          w_phase_d = '0;
        end else if (i_period_tick) begin
          if (r_state == StRamp) begin
            if (w_sum >= {1'b0, w_target}) begin
              w_duty_d  = w_target;
              w_state_d = StRun;
            end else begin
              w_duty_d = w_sum[DW-1:0];
            end
          end else begin
            w_duty_d = w_target;
            if ({1'b0, r_phase} < w_req_mask) begin
              w_phase_d = {r_phase[NPHASES-2:0], 1'b1};
            end else if ({1'b0, r_phase} > w_req_mask) begin
              w_phase_d = {1'b0, r_phase[NPHASES-1:1]};
            end
          end
        end
      end
      StFault: begin
        w_duty_d  = '0;
        w_phase_d = '0;
        if (!i_en_pwm && !i_fault) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_duty_d  = '0;
        w_phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= StIdle;
      r_duty          <= '0;
      r_phase         <= '0;
      r_ready         <= 1'b0;
      r_fault_latched <= 1'b0;
    end else begin
      r_state         <= w_state_d;
      r_duty          <= w_duty_d;
      r_phase         <= w_phase_d;
      r_ready         <= (w_state_d == StRun);
      r_fault_latched <= (w_state_d == StFault);
    end
  end

  assign o_duty_out      = r_duty;
  assign o_phase_en      = r_phase;
  assign o_state         = r_state;
  assign o_ready         = r_ready;
  assign o_fault_latched = r_fault_latched;

endmodule

// File: doc/buck_phase_sequencer.md
# buck_phase_sequencer

Start-up and phase-management controller for the 4-phase buck PWM chain. It sits between the duty sources (compensator output and SPI manual register) and the dither/DPWM input. It selects the active duty source and soft-starts it with a per-period ramp. It adds and sheds phases one PWM period at a time and shuts everything down on fault or disable. All duty and phase changes occur only on PWM period boundaries, so no pulse is ever truncated.

## Interface
- DW, 10, duty word width
- NPHASES, 4, number of phases (phase_en width)
- RAMP_STEP, 4, soft-start duty increment per PWM period
- clk  in  1  system clock (same clock as the DPWM counter)
- rst  in  1  reset; asynchronous, active-low
- period_tick  in  1  one-cycle pulse at DPWM counter wrap (start of each PWM period)
- en_pwm  in  1  converter enable (SPI register)
- mode_manual  in  1  1 = use duty_manual, 0 = use duty_loop
- duty_manual  in  DW  manual duty (SPI register)
- duty_loop  in  DW  compensator duty
- duty_max  in  DW  duty clamp
- phase_req  in  3  requested number of active phases
- fault  in  1  level fault input (overcurrent/UV), already synchronous to clk
- duty_out  out  DW  duty to dither/DPWM
- phase_en  out  NPHASES  per-phase gate enable, thermometer-coded from bit 0
- state  out  2  IDLE=0, RAMP=1, RUN=2, FAULT=3
- ready  out  1  soft-start complete (state==RUN)
- fault_latched  out  1  sticky fault flag

## Operation
- Definitions:
  - target = min(mode_manual ? duty_manual : duty_loop, duty_max), unsigned compare.
  - nreq = phase_req clamped to [1, NPHASES]; 0 maps to 1.
- IDLE:
  - duty_out=0, phase_en=0.
  - On period_tick with en_pwm=1 and fault=0, go to RAMP; phase_en=1 (phase 0 only) and duty_out=min(RAMP_STEP, target) on that same edge.
- RAMP:
  - On each period_tick, compute duty_out+RAMP_STEP in DW+1 bits.
  - If that sum >= target, set duty_out=target and go to RUN.
  - Otherwise, duty_out += RAMP_STEP.
  - If target drops below duty_out, load duty_out=target and go to RUN on that tick.
  - phase_en stays at phase 0 only.
- RUN:
  - On each period_tick, duty_out=target.
  - phase_en moves one phase toward nreq per tick: add the next-higher bit, or drop the highest set bit.
  - Never more than one change per tick. Never 0 phases while in RUN.
- FAULT:
  - duty_out=0, phase_en=0, fault_latched=1.
  - Exit to IDLE only when en_pwm=0 and fault=0; fault_latched clears on that exit.
- Global overrides, evaluated every clk and not gated by period_tick:
  - fault=1 in RAMP or RUN: go to FAULT on the next edge.
  - en_pwm=0 in RAMP or RUN: go to IDLE on the next edge, with duty_out=0 and phase_en=0.
  - Both fault and en_pwm=0 at once: FAULT wins.
  - fault=1 in IDLE: stay in IDLE and block start; fault_latched is not set.
- Changes to mode_manual, duty_manual or duty_loop between ticks have no effect until the next period_tick.

## Timing
- All outputs are registered.
- Period-gated updates take effect on the clk edge that samples period_tick=1 and are visible the following cycle.
- Overrides take effect on the first edge after fault rises or en_pwm falls (1-cycle latency).
- Reset values: state=IDLE (0), duty_out=0, phase_en=0, ready=0, fault_latched=0.
- Asserting rst mid-RAMP or mid-RUN clears all outputs immediately (asynchronous).
- Ramp length from IDLE to RUN is ceil(target/RAMP_STEP) ticks. The first tick moves IDLE→RAMP and already applies the first step.
- With target=0 at start, the first tick sets duty_out=0. The next tick goes to RUN.
- duty_out never exceeds duty_max. The ramp sum never wraps.
- period_tick held high for multiple cycles counts once per cycle; the DPWM guarantees a single-cycle pulse.

## Test plan
- Soft-start:
  - Stimulus: en_pwm=1, mode_manual=1, duty_manual=20, duty_max=1000, phase_req=4.
  - Required: duty_out steps 4,8,12,16,20 on successive ticks. RUN and ready=1 are reached on the tick that loads 20. phase_en then goes 0001→0011→0111→1111 over the next 3 ticks.
- Clamp and mode switch:
  - Stimulus: in RUN, duty_loop=900, duty_max=600, set mode_manual=0 mid-period.
  - Required: duty_out stays unchanged until the next tick, then becomes 600.
- Phase shedding:
  - Stimulus: in RUN with 4 phases, set phase_req=0.
  - Required: phase_en goes 0111, 0011, 0001 on 3 ticks and stays at 0001.
- Fault mid-ramp:
  - Stimulus: fault=1 with duty_out=8.
  - Required: next cycle duty_out=0, phase_en=0, state=3, fault_latched=1. Dropping fault alone keeps FAULT. With en_pwm=0 and fault=0, state goes to IDLE and fault_latched=0.
- Simultaneous events:
  - Stimulus: in RUN, fault rises and en_pwm falls on the same cycle.
  - Required: FAULT.
  - Stimulus: in IDLE, fault=1, en_pwm=1, tick.
  - Required: stays IDLE.
- Async reset:
  - Stimulus: assert rst low mid-RUN between clk edges.
  - Required: all outputs 0 and state=0 without waiting for an edge. Release, then with en_pwm=1 the first tick restarts the ramp at 4.
